// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - source handshakes and result-bus broadcast of the CDB arbiter
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

interface cdb_arbiter_if #(
   parameter int ROB_ID_W = `ROB_WIDTH_BIT
);
   logic                rdy_in;
   logic                clear_all;

   logic                alu_valid;
   logic [31:0]         alu_value;
   logic [ROB_ID_W-1:0] alu_dest;
   logic [31:0]         alu_jalr_pc;
   logic                alu_ready;

   logic                lb_valid;
   logic [31:0]         lb_value;
   logic [ROB_ID_W-1:0] lb_dest;
   logic                lb_ready;

   logic                sb_valid;
   logic [ROB_ID_W-1:0] sb_dest;
   logic                sb_ready;

   logic                cdb_valid;
   logic [1:0]          cdb_src;
   logic [ROB_ID_W-1:0] cdb_dest;
   logic [31:0]         cdb_value;
   logic [31:0]         cdb_jalr_pc;

   modport slave (
      input  rdy_in, clear_all,
      input  alu_valid, alu_value, alu_dest, alu_jalr_pc,
      input  lb_valid, lb_value, lb_dest,
      input  sb_valid, sb_dest,
      output alu_ready, lb_ready, sb_ready,
      output cdb_valid, cdb_src, cdb_dest, cdb_value, cdb_jalr_pc
   );

   modport master (
      output rdy_in, clear_all,
      output alu_valid, alu_value, alu_dest, alu_jalr_pc,
      output lb_valid, lb_value, lb_dest,
      output sb_valid, sb_dest,
      input  alu_ready, lb_ready, sb_ready,
      input  cdb_valid, cdb_src, cdb_dest, cdb_value, cdb_jalr_pc
   );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin result-bus arbiter, one holding slot per ALU/LB/SB source
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

module cdb_arbiter #(
   parameter int ROB_ID_W = `ROB_WIDTH_BIT
) (
   input  logic           clk_in,
   input  logic           rst_in,
   cdb_arbiter_if.slave   bus
);
   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_SB  = 2'd2;

   logic [2:0]                full_q, full_d;
   logic [2:0][ROB_ID_W-1:0]  dest_q, dest_d;
   logic [1:0][31:0]          value_q, value_d;
   logic [31:0]               jalr_q, jalr_d;
   logic [1:0]                rr_q, rr_d;

   logic                      cdb_valid_q, cdb_valid_d;
   logic [1:0]                cdb_src_q, cdb_src_d;
   logic [ROB_ID_W-1:0]       cdb_dest_q, cdb_dest_d;
   logic [31:0]               cdb_value_q, cdb_value_d;
   logic [31:0]               cdb_jalr_q, cdb_jalr_d;

   logic                      gnt_any;
   logic [1:0]                gnt_idx;
   logic [1:0]                scan_idx;
   logic [2:0]                gnt;
   logic [2:0]                ready;
   logic [2:0]                accept;

   function automatic logic [1:0] inc3(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = rr_q;
      scan_idx = rr_q;
      for (int k = 0; k < 3; k++) begin
         if (!gnt_any && full_q[scan_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_idx;
         end
         scan_idx = inc3(scan_idx);
      end
      gnt = gnt_any ? (3'b001 << gnt_idx) : 3'b000;
   end

   // A granted slot drains this edge, so it may be refilled in the same cycle.
   assign ready  = {3{bus.rdy_in & ~bus.clear_all & ~rst_in}} & (~full_q | gnt);
   assign accept = {bus.sb_valid, bus.lb_valid, bus.alu_valid} & ready;

   always_comb begin
      full_d      = full_q;
      dest_d      = dest_q;
      value_d     = value_q;
      jalr_d      = jalr_q;
      rr_d        = rr_q;
      cdb_valid_d = cdb_valid_q;
      cdb_src_d   = cdb_src_q;
      cdb_dest_d  = cdb_dest_q;
      cdb_value_d = cdb_value_q;
      cdb_jalr_d  = cdb_jalr_q;

      if (bus.rdy_in) begin
         if (bus.clear_all) begin
            full_d      = 3'b000;
            cdb_valid_d = 1'b0;
            rr_d        = 2'd0;
         end else begin
            cdb_valid_d = gnt_any;
            if (gnt_any) begin
               cdb_src_d         = gnt_idx;
               cdb_dest_d        = dest_q[gnt_idx];
               cdb_value_d       = (gnt_idx == SRC_SB) ? 32'd0 : value_q[gnt_idx[0]];
               cdb_jalr_d        = (gnt_idx == SRC_ALU) ? jalr_q : 32'd0;
               full_d[gnt_idx]   = 1'b0;
               rr_d              = inc3(gnt_idx);
            end
            if (accept[0]) begin
               full_d[0]  = 1'b1;
               dest_d[0]  = bus.alu_dest;
               value_d[0] = bus.alu_value;
               jalr_d     = bus.alu_jalr_pc;
            end
            if (accept[1]) begin
               full_d[1]  = 1'b1;
               dest_d[1]  = bus.lb_dest;
               value_d[1] = bus.lb_value;
            end
            if (accept[2]) begin
               full_d[2]  = 1'b1;
               dest_d[2]  = bus.sb_dest;
            end
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         full_q      <= '0;
         dest_q      <= '0;
         value_q     <= '0;
         jalr_q      <= '0;
         rr_q        <= '0;
         cdb_valid_q <= 1'b0;
         cdb_src_q   <= '0;
         cdb_dest_q  <= '0;
         cdb_value_q <= '0;
         cdb_jalr_q  <= '0;
      end else begin
         full_q      <= full_d;
         dest_q      <= dest_d;
         value_q     <= value_d;
         jalr_q      <= jalr_d;
         rr_q        <= rr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_src_q   <= cdb_src_d;
         cdb_dest_q  <= cdb_dest_d;
         cdb_value_q <= cdb_value_d;
         cdb_jalr_q  <= cdb_jalr_d;
      end
   end

   assign bus.alu_ready   = ready[0];
   assign bus.lb_ready    = ready[1];
   assign bus.sb_ready    = ready[2];
   assign bus.cdb_valid   = cdb_valid_q;
   assign bus.cdb_src     = cdb_src_q;
   assign bus.cdb_dest    = cdb_dest_q;
   assign bus.cdb_value   = cdb_value_q;
   assign bus.cdb_jalr_pc = cdb_jalr_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
   localparam int W = 4;

   typedef struct packed {
      logic [1:0]  src;
      logic [W-1:0] dest;
      logic [31:0] value;
      logic [31:0] jalr;
   } exp_t;

   logic clk;
   logic rst;
   logic rdy_prev;
   int   n_cmp;
   int   n_err;
   exp_t exp_q[$];

   cdb_arbiter_if #(.ROB_ID_W(W)) bus();

   cdb_arbiter #(.ROB_ID_W(W)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [1:0] s, input logic [W-1:0] d,
                               input logic [31:0] v, input logic [31:0] j);
      exp_t e;
      e.src = s; e.dest = d; e.value = v; e.jalr = j;
      return e;
   endfunction

   always @(posedge clk) rdy_prev <= bus.rdy_in;

   always @(negedge clk) begin
      if (!rst && rdy_prev && bus.cdb_valid) begin
         if (exp_q.size() == 0) begin
            check_val("cdb_unexpected", 64'(bus.cdb_valid), 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_val("sb_src",   64'(bus.cdb_src),     64'(e.src));
            check_val("sb_dest",  64'(bus.cdb_dest),    64'(e.dest));
            check_val("sb_value", 64'(bus.cdb_value),   64'(e.value));
            check_val("sb_jalr",  64'(bus.cdb_jalr_pc), 64'(e.jalr));
         end
      end
   end

   initial begin
      int  i;
      int  budget;
      logic acc_a;
      logic acc_l;

      n_cmp = 0; n_err = 0; rdy_prev = 1'b0;
      rst = 1'b1;
      bus.rdy_in = 1'b1; bus.clear_all = 1'b0;
      bus.alu_valid = 1'b0; bus.alu_value = '0; bus.alu_dest = '0; bus.alu_jalr_pc = '0;
      bus.lb_valid = 1'b0; bus.lb_value = '0; bus.lb_dest = '0;
      bus.sb_valid = 1'b0; bus.sb_dest = '0;

      repeat (2) @(posedge clk);
      #1;
      check_val("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
      check_val("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
      rst = 1'b0;
      #1;
      check_val("post_rst_readys", 64'({bus.alu_ready, bus.lb_ready, bus.sb_ready}), 64'b111);

      // single ALU result: accepted at edge 0, broadcast after edge 1
      @(posedge clk); #1;
      bus.alu_valid = 1'b1; bus.alu_dest = 4'd5; bus.alu_value = 32'h1234; bus.alu_jalr_pc = 32'h100;
      exp_q.push_back(mk(2'd0, 4'd5, 32'h1234, 32'h100));
      @(posedge clk); #1;
      bus.alu_valid = 1'b0;
      @(posedge clk); #1;
      check_val("single_valid", 64'(bus.cdb_valid),   64'd1);
      check_val("single_src",   64'(bus.cdb_src),     64'd0);
      check_val("single_dest",  64'(bus.cdb_dest),    64'd5);
      check_val("single_value", 64'(bus.cdb_value),   64'h1234);
      check_val("single_jalr",  64'(bus.cdb_jalr_pc), 64'h100);
      @(posedge clk); #1;
      check_val("single_drop",  64'(bus.cdb_valid),   64'd0);

      // asynchronous reset mid-cycle
      #2;
      rst = 1'b1;
      #1;
      check_val("arst_dest",   64'(bus.cdb_dest),    64'd0);
      check_val("arst_value",  64'(bus.cdb_value),   64'd0);
      check_val("arst_jalr",   64'(bus.cdb_jalr_pc), 64'd0);
      check_val("arst_readys", 64'({bus.alu_ready, bus.lb_ready, bus.sb_ready}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check_val("arst_release", 64'({bus.alu_ready, bus.lb_ready, bus.sb_ready}), 64'b111);

      // three-way contention from rr = 0
      @(posedge clk); #1;
      bus.alu_valid = 1'b1; bus.alu_dest = 4'd1; bus.alu_value = 32'hA; bus.alu_jalr_pc = 32'h20;
      bus.lb_valid = 1'b1; bus.lb_dest = 4'd2; bus.lb_value = 32'd7;
      bus.sb_valid = 1'b1; bus.sb_dest = 4'd3;
      exp_q.push_back(mk(2'd0, 4'd1, 32'hA, 32'h20));
      exp_q.push_back(mk(2'd1, 4'd2, 32'd7, 32'd0));
      exp_q.push_back(mk(2'd2, 4'd3, 32'd0, 32'd0));
      @(posedge clk); #1;
      bus.alu_valid = 1'b0; bus.lb_valid = 1'b0; bus.sb_valid = 1'b0;
      @(posedge clk); #1;
      check_val("cont_dest1", 64'(bus.cdb_dest), 64'd1);
      @(posedge clk); #1;
      check_val("cont_dest2", 64'(bus.cdb_dest), 64'd2);
      @(posedge clk); #1;
      check_val("cont_dest3", 64'(bus.cdb_dest), 64'd3);
      check_val("cont_sb_value", 64'(bus.cdb_value), 64'd0);
      @(posedge clk); #1;

      // fairness: ALU streams dests 0..7, one LB result must slot in second
      exp_q.push_back(mk(2'd0, 4'd0, 32'h100, 32'd0));
      exp_q.push_back(mk(2'd1, 4'd8, 32'h55, 32'd0));
      for (int k = 1; k < 8; k++) exp_q.push_back(mk(2'd0, 4'(k), 32'h100 + 32'(k), 32'd0));
      i = 0; budget = 0;
      bus.lb_valid = 1'b1; bus.lb_dest = 4'd8; bus.lb_value = 32'h55;
      while (i < 8 && budget < 40) begin
         bus.alu_valid = 1'b1; bus.alu_dest = 4'(i); bus.alu_value = 32'h100 + 32'(i); bus.alu_jalr_pc = 32'd0;
         @(negedge clk);
         acc_a = bus.alu_ready;
         acc_l = bus.lb_valid & bus.lb_ready;
         @(posedge clk); #1;
         if (acc_a) i++;
         if (acc_l) bus.lb_valid = 1'b0;
         budget++;
      end
      bus.alu_valid = 1'b0; bus.lb_valid = 1'b0;
      check_val("fair_budget_ok", 64'(budget < 40), 64'd1);
      repeat (4) @(posedge clk);
      #1;
      check_val("fair_drained", 64'(exp_q.size()), 64'd0);

      // flush: fill all slots, then clear_all with a fresh ALU offer
      bus.alu_valid = 1'b1; bus.alu_dest = 4'd4; bus.alu_value = 32'h44; bus.alu_jalr_pc = 32'h8;
      bus.lb_valid = 1'b1; bus.lb_dest = 4'd5; bus.lb_value = 32'h55;
      bus.sb_valid = 1'b1; bus.sb_dest = 4'd6;
      @(posedge clk); #1;
      bus.lb_valid = 1'b0; bus.sb_valid = 1'b0;
      bus.clear_all = 1'b1; bus.alu_dest = 4'd7;
      #1;
      check_val("flush_alu_ready", 64'(bus.alu_ready), 64'd0);
      check_val("flush_lb_ready",  64'(bus.lb_ready),  64'd0);
      @(posedge clk); #1;
      check_val("flush_valid", 64'(bus.cdb_valid), 64'd0);
      bus.clear_all = 1'b0; bus.alu_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("flush_quiet", 64'(bus.cdb_valid), 64'd0);

      // rr must be 0 after the flush: ALU wins over SB
      bus.alu_valid = 1'b1; bus.alu_dest = 4'd9; bus.alu_value = 32'h99; bus.alu_jalr_pc = 32'h44;
      bus.sb_valid = 1'b1; bus.sb_dest = 4'd10;
      exp_q.push_back(mk(2'd0, 4'd9, 32'h99, 32'h44));
      exp_q.push_back(mk(2'd2, 4'd10, 32'd0, 32'd0));
      @(posedge clk); #1;
      bus.alu_valid = 1'b0; bus.sb_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // pause with the LB slot full; clear_all must be ignored meanwhile
      bus.lb_valid = 1'b1; bus.lb_dest = 4'd11; bus.lb_value = 32'h77;
      exp_q.push_back(mk(2'd1, 4'd11, 32'h77, 32'd0));
      @(posedge clk); #1;
      bus.lb_valid = 1'b0; bus.rdy_in = 1'b0; bus.clear_all = 1'b1; bus.alu_valid = 1'b1;
      #1;
      check_val("pause_readys", 64'({bus.alu_ready, bus.lb_ready, bus.sb_ready}), 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check_val("pause_valid", 64'(bus.cdb_valid), 64'd0);
         check_val("pause_src",   64'(bus.cdb_src),   64'd2);
         check_val("pause_dest",  64'(bus.cdb_dest),  64'd10);
      end
      bus.clear_all = 1'b0; bus.alu_valid = 1'b0; bus.rdy_in = 1'b1;
      @(posedge clk); #1;
      check_val("resume_valid", 64'(bus.cdb_valid), 64'd1);
      check_val("resume_dest",  64'(bus.cdb_dest),  64'd11);
      repeat (3) @(posedge clk);
      #1;
      check_val("final_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
